// File: rtl/conv_layer_ctrl_gen.sv
// conv_layer_ctrl_gen: walks oy, ox, group, ky, kx for one conv layer, issuing activation/weight
// read addresses and latency-aligned accumulator-clear / output-write strobes.
module conv_layer_ctrl_gen #(
  parameter int IN_W       = 32,
  parameter int IN_H       = 32,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int CIN_GROUPS = 1,
  parameter int PIPE_LAT   = 3,
  parameter int ADDR_W     = 10,
  parameter int WADDR_W    = 4,
  parameter int OADDR_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               rd_valid,
  output logic               acc_clr,
  output logic               out_we,
  output logic [OADDR_W-1:0] out_addr
);
  localparam int OUT_W = (IN_W - K) / STRIDE + 1;
  localparam int OUT_H = (IN_H - K) / STRIDE + 1;
  localparam int KW = $clog2(K + 1);
  localparam int GW = $clog2(CIN_GROUPS + 1);
  localparam int XW = $clog2(OUT_W + 1);
  localparam int YW = $clog2(OUT_H + 1);
  localparam int LW = $clog2(PIPE_LAT + 1);
  localparam logic [KW-1:0] K_M1 = KW'(K - 1);
  localparam logic [GW-1:0] G_M1 = GW'(CIN_GROUPS - 1);
  localparam logic [XW-1:0] X_M1 = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_M1 = YW'(OUT_H - 1);
  localparam logic [LW-1:0] L_M1 = LW'(PIPE_LAT - 1);
  localparam logic [ADDR_W-1:0] A_ROW   = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] A_PLANE = ADDR_W'(IN_W * IN_H);
  localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] A_OROW  = ADDR_W'(STRIDE * IN_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_d;

  logic [KW-1:0] kx, ky;
  logic [GW-1:0] g;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [ADDR_W-1:0] row0, pix_base, grp_base, row_base;
  logic [ADDR_W-1:0] nxt_row, nxt_grp, nxt_pix, nxt_row0;
  logic [OADDR_W-1:0] pix;
  logic [LW-1:0] drain_cnt;
  logic [PIPE_LAT-1:0] dl_clr, dl_we;
  logic [PIPE_LAT-1:0][OADDR_W-1:0] dl_addr;
  logic first, last_g, last_tap, live, drain_end;

  assign first     = kx == '0 && ky == '0 && g == '0;
  assign last_g    = kx == K_M1 && ky == K_M1 && g == G_M1;
  assign last_tap  = last_g && ox == X_M1 && oy == Y_M1;
  assign live      = state == RUN;
  assign drain_end = drain_cnt == L_M1;
  assign nxt_row   = row_base + A_ROW;
  assign nxt_grp   = grp_base + A_PLANE;
  assign nxt_pix   = pix_base + A_STEP;
  assign nxt_row0  = row0 + A_OROW;
  assign acc_clr   = dl_clr[PIPE_LAT-1];
  assign out_we    = dl_we[PIPE_LAT-1];
  assign out_addr  = dl_addr[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    if (!stall)
      unique case (state)
        IDLE:    state_d = start ? RUN : IDLE;
        RUN:     state_d = last_tap ? DRAIN : RUN;
        DRAIN:   state_d = drain_end ? DONE : DRAIN;
        default: state_d = IDLE;
      endcase
  end

  // Address registers track the tap currently presented; bases step by adds only.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      rd_valid <= 1'b0;
      in_addr <= '0;
      w_addr <= '0;
      {kx, ky, g, ox, oy, pix, drain_cnt} <= '0;
      {row0, pix_base, grp_base, row_base} <= '0;
      dl_clr <= '0;
      dl_we <= '0;
      dl_addr <= '0;
    end else begin
      busy <= state_d == RUN || state_d == DRAIN;
      done <= state_d == DONE;
      rd_valid <= !stall && state_d == RUN;
      if (!stall) begin
        dl_clr[0] <= live && first;
        dl_we[0] <= live && last_g;
        dl_addr[0] <= pix;
        for (int i = 1; i < PIPE_LAT; i++) begin
          dl_clr[i] <= dl_clr[i-1];
          dl_we[i] <= dl_we[i-1];
          dl_addr[i] <= dl_addr[i-1];
        end
        drain_cnt <= state == DRAIN ? drain_cnt + LW'(1) : '0;
        if (state == IDLE) begin
          in_addr <= '0;
          w_addr <= '0;
          {kx, ky, g, ox, oy, pix} <= '0;
          {row0, pix_base, grp_base, row_base} <= '0;
        end else if (live && !last_tap) begin
          w_addr <= last_g ? '0 : w_addr + WADDR_W'(1);
          kx <= kx == K_M1 ? '0 : kx + KW'(1);
          if (kx != K_M1) in_addr <= in_addr + ADDR_W'(1);
          else if (ky != K_M1) begin
            ky <= ky + KW'(1);
            row_base <= nxt_row;
            in_addr <= nxt_row;
          end else if (g != G_M1) begin
            ky <= '0;
            g <= g + GW'(1);
            {grp_base, row_base, in_addr} <= {3{nxt_grp}};
          end else begin
            ky <= '0;
            g <= '0;
            pix <= pix + OADDR_W'(1);
            if (ox != X_M1) begin
              ox <= ox + XW'(1);
              {pix_base, grp_base, row_base, in_addr} <= {4{nxt_pix}};
            end else begin
              ox <= '0;
              oy <= oy + YW'(1);
              {row0, pix_base, grp_base, row_base, in_addr} <= {5{nxt_row0}};
            end
          end
        end
      end
    end
endmodule

// File: tb/tb_conv_layer_ctrl_gen.sv
// tb_conv_layer_ctrl_gen: table-driven layer passes on three configurations plus reset corner cases.
module tb_conv_layer_ctrl_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int sel = 0;
  logic start_drv = 1'b0;
  logic stall_drv = 1'b0;

  logic d_busy, d_done, d_rv, d_clr, d_we;
  logic [9:0] d_in, d_oa;
  logic [3:0] d_w;
  logic a_start, a_stall, a_busy, a_done, a_rv, a_clr, a_we;
  logic [5:0] a_in;
  logic [4:0] a_w;
  logic [3:0] a_oa;
  logic b_start, b_stall, b_busy, b_done, b_rv, b_clr, b_we;
  logic [5:0] b_in;
  logic [3:0] b_w, b_oa;
  logic c_start, c_stall, c_busy, c_done, c_rv, c_clr, c_we;
  logic [3:0] c_in, c_oa;
  logic [0:0] c_w;

  assign a_start = start_drv && sel == 0;
  assign b_start = start_drv && sel == 1;
  assign c_start = start_drv && sel == 2;
  assign a_stall = stall_drv && sel == 0;
  assign b_stall = stall_drv && sel == 1;
  assign c_stall = stall_drv && sel == 2;

  conv_layer_ctrl_gen u_d (
    .clk(clk), .rst(rst), .start(1'b0), .stall(1'b0), .busy(d_busy), .done(d_done),
    .in_addr(d_in), .w_addr(d_w), .rd_valid(d_rv), .acc_clr(d_clr), .out_we(d_we), .out_addr(d_oa));

  conv_layer_ctrl_gen #(.IN_W(5), .IN_H(5), .K(3), .STRIDE(1), .CIN_GROUPS(2), .PIPE_LAT(2),
    .ADDR_W(6), .WADDR_W(5), .OADDR_W(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .stall(a_stall), .busy(a_busy), .done(a_done),
    .in_addr(a_in), .w_addr(a_w), .rd_valid(a_rv), .acc_clr(a_clr), .out_we(a_we), .out_addr(a_oa));

  conv_layer_ctrl_gen #(.IN_W(7), .IN_H(7), .K(3), .STRIDE(2), .CIN_GROUPS(1), .PIPE_LAT(3),
    .ADDR_W(6), .WADDR_W(4), .OADDR_W(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .stall(b_stall), .busy(b_busy), .done(b_done),
    .in_addr(b_in), .w_addr(b_w), .rd_valid(b_rv), .acc_clr(b_clr), .out_we(b_we), .out_addr(b_oa));

  conv_layer_ctrl_gen #(.IN_W(4), .IN_H(4), .K(1), .STRIDE(1), .CIN_GROUPS(1), .PIPE_LAT(1),
    .ADDR_W(4), .WADDR_W(1), .OADDR_W(4)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .stall(c_stall), .busy(c_busy), .done(c_done),
    .in_addr(c_in), .w_addr(c_w), .rd_valid(c_rv), .acc_clr(c_clr), .out_we(c_we), .out_addr(c_oa));

  logic m_rv, m_clr, m_we, m_done, m_busy;
  int m_in, m_w, m_oa;
  assign m_rv   = sel == 0 ? a_rv   : sel == 1 ? b_rv   : c_rv;
  assign m_clr  = sel == 0 ? a_clr  : sel == 1 ? b_clr  : c_clr;
  assign m_we   = sel == 0 ? a_we   : sel == 1 ? b_we   : c_we;
  assign m_done = sel == 0 ? a_done : sel == 1 ? b_done : c_done;
  assign m_busy = sel == 0 ? a_busy : sel == 1 ? b_busy : c_busy;
  assign m_in = sel == 0 ? int'(a_in) : sel == 1 ? int'(b_in) : int'(c_in);
  assign m_w  = sel == 0 ? int'(a_w)  : sel == 1 ? int'(b_w)  : int'(c_w);
  assign m_oa = sel == 0 ? int'(a_oa) : sel == 1 ? int'(b_oa) : int'(c_oa);

  // Event log of the selected DUT, cycle numbers relative to the start edge (first tap = 1).
  logic log_en = 1'b0;
  int t0 = 0;
  int busy1, busyd;
  int t_in[$], t_w[$], t_cyc[$], c_cyc[$], w_cyc[$], w_ad[$], d_cyc[$];
  always @(negedge clk)
    if (log_en) begin
      if (m_rv) begin
        t_in.push_back(m_in);
        t_w.push_back(m_w);
        t_cyc.push_back(cyc - t0 + 1);
      end
      if (m_clr) c_cyc.push_back(cyc - t0 + 1);
      if (m_we) begin
        w_cyc.push_back(cyc - t0 + 1);
        w_ad.push_back(m_oa);
      end
      if (m_done) begin
        d_cyc.push_back(cyc - t0 + 1);
        busyd = int'(m_busy);
      end
      if (cyc - t0 + 1 == 1) busy1 = int'(m_busy);
    end

  typedef struct {
    int sel, iw, ih, k, s, g, lat, stall_at, stall_len, glitch_at;
    int taps, writes, first_clr, first_we, done_rel, last_in;
  } scen_t;
  scen_t v[5];
  int a18[18];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sh(input int x, input int at, input int len);
    return (len > 0 && x > at) ? x + len : x;
  endfunction

  task automatic run_pass(input scen_t s);
    int e_in[$], e_w[$];
    int ow, oh, tpp, np, rel;
    ow = (s.iw - s.k) / s.s + 1;
    oh = (s.ih - s.k) / s.s + 1;
    tpp = s.g * s.k * s.k;
    np = ow * oh;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int gg = 0; gg < s.g; gg++)
          for (int ky = 0; ky < s.k; ky++)
            for (int kx = 0; kx < s.k; kx++) begin
              e_in.push_back(gg * s.iw * s.ih + (oy * s.s + ky) * s.iw + ox * s.s + kx);
              e_w.push_back(gg * s.k * s.k + ky * s.k + kx);
            end
    t_in.delete(); t_w.delete(); t_cyc.delete(); c_cyc.delete();
    w_cyc.delete(); w_ad.delete(); d_cyc.delete();
    busy1 = -1;
    busyd = -1;
    @(negedge clk);
    sel = s.sel;
    t0 = cyc + 1;
    log_en = 1'b1;
    start_drv = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rel = cyc - t0 + 1;
      start_drv = rel == s.glitch_at;
      stall_drv = rel >= s.stall_at && rel < s.stall_at + s.stall_len;
      if (d_cyc.size() > 0 && rel > d_cyc[0] + 4) break;
    end
    log_en = 1'b0;
    start_drv = 1'b0;
    stall_drv = 1'b0;
    if (d_cyc.size() == 0) chk("done_timeout", 0, 1);
    chk("tap_count", t_in.size(), s.taps);
    for (int i = 0; i < e_in.size() && i < t_in.size(); i++) begin
      chk($sformatf("tap_in[%0d]", i), t_in[i], e_in[i]);
      chk($sformatf("tap_w[%0d]", i), t_w[i], e_w[i]);
      chk($sformatf("tap_cyc[%0d]", i), t_cyc[i], sh(i + 1, s.stall_at, s.stall_len));
    end
    chk("write_count", w_cyc.size(), s.writes);
    chk("clr_count", c_cyc.size(), np);
    for (int p = 0; p < np && p < w_cyc.size(); p++) begin
      chk($sformatf("we_cyc[%0d]", p), w_cyc[p], sh((p + 1) * tpp + s.lat, s.stall_at, s.stall_len));
      chk($sformatf("we_addr[%0d]", p), w_ad[p], p);
    end
    for (int p = 0; p < np && p < c_cyc.size(); p++)
      chk($sformatf("clr_cyc[%0d]", p), c_cyc[p], sh(p * tpp + 1 + s.lat, s.stall_at, s.stall_len));
    chk("first_clr", c_cyc.size() > 0 ? c_cyc[0] : -1, s.first_clr);
    chk("first_we", w_cyc.size() > 0 ? w_cyc[0] : -1, s.first_we);
    chk("last_in", t_in.size() > 0 ? t_in[t_in.size() - 1] : -1, s.last_in);
    chk("done_count", d_cyc.size(), 1);
    chk("done_cyc", d_cyc.size() > 0 ? d_cyc[0] : -1, s.done_rel);
    chk("busy_first", busy1, 1);
    chk("busy_at_done", busyd, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v[0] = '{0, 5, 5, 3, 1, 2, 2, 0, 0, 0, 162, 9, 3, 20, 165, 49};
    v[1] = '{0, 5, 5, 3, 1, 2, 2, 25, 5, 0, 162, 9, 3, 20, 170, 49};
    v[2] = '{0, 5, 5, 3, 1, 2, 2, 0, 0, 50, 162, 9, 3, 20, 165, 49};
    v[3] = '{1, 7, 7, 3, 2, 1, 3, 0, 0, 0, 81, 9, 4, 12, 85, 48};
    v[4] = '{2, 4, 4, 1, 1, 1, 1, 0, 0, 0, 16, 16, 2, 2, 18, 15};
    a18 = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 25, 26, 27, 30, 31, 32, 35, 36, 37};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(d_busy), 0);
    chk("idle_done", int'(d_done), 0);
    chk("idle_rd_valid", int'(d_rv), 0);
    chk("idle_acc_clr", int'(d_clr), 0);
    chk("idle_out_we", int'(d_we), 0);
    chk("idle_in_addr", int'(d_in), 0);
    chk("idle_w_addr", int'(d_w), 0);
    chk("idle_out_addr", int'(d_oa), 0);
    for (int i = 0; i < 5; i++) begin
      run_pass(v[i]);
      if (i == 0)
        for (int j = 0; j < 18 && j < t_in.size(); j++) begin
          chk($sformatf("a18_in[%0d]", j), t_in[j], a18[j]);
          chk($sformatf("a18_w[%0d]", j), t_w[j], j);
        end
      if (i == 3) begin
        chk("pix01_in", t_in.size() > 9 ? t_in[9] : -1, 2);
        chk("pix10_in", t_in.size() > 27 ? t_in[27] : -1, 14);
      end
    end
    sel = 0;
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", int'(a_busy), 1);
    rst = 1'b0;
    #1;
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_rd_valid", int'(a_rv), 0);
    chk("rst_acc_clr", int'(a_clr), 0);
    chk("rst_out_we", int'(a_we), 0);
    chk("rst_in_addr", int'(a_in), 0);
    chk("rst_w_addr", int'(a_w), 0);
    chk("rst_out_addr", int'(a_oa), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", int'(a_busy), 0);
    run_pass(v[0]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
